// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared forward-select codes and hazard FSM states
package pipeline_pkg;

  // Execute-stage operand mux selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Multi-cycle execute sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_RUN  = 2'd1,
    ST_MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - combinational operand forwarding and load-use detect
module hazard_forward_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWrtM,
  input  logic                  RegWrtW,
  input  logic                  ResultSrcE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  lw_stall
);

  // Mem result is younger than Writeback, so it wins; x0 is hardwired zero
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (RegWrtM && (RdM != '0) && (RdM == rs))
      return FWD_MEM;
    else if (RegWrtW && (RdW != '0) && (RdW == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // Forward selects for both Execute operands
  always_comb begin
    ForwardAE = fwd_sel(Rs1E);
    ForwardBE = fwd_sel(Rs2E);
  end

  // A load in Execute feeding the instruction in Decode needs one bubble
  always_comb begin
    lw_stall = ResultSrcE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush control and multi-cycle op sequencer
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWrtM,
  input  logic                  RegWrtW,
  input  logic                  ResultSrcE,
  input  logic                  PCSrcE,
  input  logic                  MdStartE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  MdBusy,
  output logic                  MdDone,
  output logic [CNT_W-1:0]      StallCycles
);

  // Cycles spent in MD_RUN: the entry cycle and the MD_DONE cycle make up the rest
  localparam logic [7:0] MD_RUN_CYCLES = 8'(MD_LATENCY - 2);

  md_state_e  state;
  logic [7:0] md_cnt;
  logic       lw_stall;
  logic       md_go;
  logic       md_hold;

  hazard_forward_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd (
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWrtM    (RegWrtM),
    .RegWrtW    (RegWrtW),
    .ResultSrcE (ResultSrcE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .lw_stall   (lw_stall)
  );

  // Front of the pipe is frozen from the op's first execute cycle through its last MD_RUN cycle;
  // a start is not accepted while reset is held so all stalls drop immediately on reset
  always_comb begin
    md_go   = (state == ST_IDLE) && MdStartE && rst;
    md_hold = md_go || (state == ST_MD_RUN);
  end

  // Stall/flush priority: multi-cycle hold, then taken branch, then load-use
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    MdBusy = 1'b0;
    MdDone = 1'b0;
    if (md_hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
      MdBusy = 1'b1;
    end else begin
      if (state == ST_MD_DONE) begin
        MdBusy = 1'b1;
        MdDone = 1'b1;
      end
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // Sequencer: md_cnt holds the MD_RUN cycles still to go
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      md_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MdStartE) begin
            md_cnt <= MD_RUN_CYCLES;
            state  <= (MD_RUN_CYCLES == 8'd0) ? ST_MD_DONE : ST_MD_RUN;
          end
        end
        ST_MD_RUN: begin
          md_cnt <= md_cnt - 8'd1;
          if (md_cnt <= 8'd1)
            state <= ST_MD_DONE;
        end
        ST_MD_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          md_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      StallCycles <= '0;
    else if (StallF && (StallCycles != {CNT_W{1'b1}}))
      StallCycles <= StallCycles + 1'b1;
  end

endmodule
